// File: rtl/qpsk_demod_if.sv
// Sample-in / decision-out bundle between the ADC capture logic, the QPSK demodulator
// and the downstream bit sink.
interface qpsk_demod_if;
    logic [11:0] Sin;
    logic        SVin;
    logic        SYNCin;
    logic [1:0]  Symout;
    logic        SymValid;
    logic        Erase;
    logic        Dout;
    logic        DValid;
    logic        Locked;

    modport master (
        output Sin, SVin, SYNCin,
        input  Symout, SymValid, Erase, Dout, DValid, Locked
    );

    modport slave (
        input  Sin, SVin, SYNCin,
        output Symout, SymValid, Erase, Dout, DValid, Locked
    );
endinterface

// File: rtl/qpsk_demod.sv
// QPSK demodulator: sign-reference I/Q correlation over one carrier cycle per symbol,
// sign slicing with an energy-based erasure flag, and a 2-bit serializer.
module qpsk_demod #(
    parameter int unsigned SPS    = 16,
    parameter int unsigned THRESH = 1024
) (
    input  logic         CLKin,
    input  logic         RESET,
    qpsk_demod_if.slave  bus
);

    localparam int unsigned KW = $clog2(SPS);
    localparam int unsigned AW = 13 + KW;
    localparam int unsigned EW = AW + 1;

    typedef enum logic {HUNT, TRACK} state_t;

    state_t                r_state,    w_state_nxt;
    logic [KW-1:0]         r_k,        w_k_nxt;
    logic signed [AW-1:0]  r_acc_i,    w_acc_i_nxt;
    logic signed [AW-1:0]  r_acc_q,    w_acc_q_nxt;
    logic signed [AW-1:0]  r_fin_i,    w_fin_i_nxt;
    logic signed [AW-1:0]  r_fin_q,    w_fin_q_nxt;
    logic                  r_dec_pend, w_dec_pend_nxt;
    logic [1:0]            r_sym,      w_sym_nxt;
    logic                  r_sym_valid, w_sym_valid_nxt;
    logic                  r_erase,    w_erase_nxt;
    logic                  r_dout,     w_dout_nxt;
    logic                  r_dvalid,   w_dvalid_nxt;
    logic                  r_ser_q,    w_ser_q_nxt;
    logic                  r_locked,   w_locked_nxt;

    logic signed [12:0]    w_s;
    logic signed [AW-1:0]  w_s_ext;
    logic                  w_cpos;
    logic                  w_spos;
    logic signed [AW-1:0]  w_term_i;
    logic signed [AW-1:0]  w_term_q;
    logic signed [AW-1:0]  w_sum_i;
    logic signed [AW-1:0]  w_sum_q;
    logic [AW-1:0]         w_abs_i;
    logic [AW-1:0]         w_abs_q;
    logic [EW-1:0]         w_mag;
    logic                  w_low;

    // Offset binary to two's complement: flipping the MSB subtracts midscale.
    assign w_s     = {~bus.Sin[11], ~bus.Sin[11], bus.Sin[10:0]};
    assign w_s_ext = AW'(w_s);

    // cref is +1 in the first and last quarter, sref in the first half.
    assign w_cpos   = (r_k[KW-1] == r_k[KW-2]);
    assign w_spos   = ~r_k[KW-1];
    assign w_term_i = w_cpos ? w_s_ext : -w_s_ext;
    assign w_term_q = w_spos ? w_s_ext : -w_s_ext;
    assign w_sum_i  = r_acc_i + w_term_i;
    assign w_sum_q  = r_acc_q + w_term_q;

    // Decision energy from the latched final accumulators.
    assign w_abs_i = r_fin_i[AW-1] ? $unsigned(-r_fin_i) : $unsigned(r_fin_i);
    assign w_abs_q = r_fin_q[AW-1] ? $unsigned(-r_fin_q) : $unsigned(r_fin_q);
    assign w_mag   = EW'(w_abs_i) + EW'(w_abs_q);
    assign w_low   = (w_mag < EW'(THRESH));

    // State register.
    always_ff @(posedge CLKin) begin
        if (RESET) begin
            r_state     <= HUNT;
            r_k         <= '0;
            r_acc_i     <= '0;
            r_acc_q     <= '0;
            r_fin_i     <= '0;
            r_fin_q     <= '0;
            r_dec_pend  <= 1'b0;
            r_sym       <= 2'b00;
            r_sym_valid <= 1'b0;
            r_erase     <= 1'b0;
            r_dout      <= 1'b0;
            r_dvalid    <= 1'b0;
            r_ser_q     <= 1'b0;
            r_locked    <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_k         <= w_k_nxt;
            r_acc_i     <= w_acc_i_nxt;
            r_acc_q     <= w_acc_q_nxt;
            r_fin_i     <= w_fin_i_nxt;
            r_fin_q     <= w_fin_q_nxt;
            r_dec_pend  <= w_dec_pend_nxt;
            r_sym       <= w_sym_nxt;
            r_sym_valid <= w_sym_valid_nxt;
            r_erase     <= w_erase_nxt;
            r_dout      <= w_dout_nxt;
            r_dvalid    <= w_dvalid_nxt;
            r_ser_q     <= w_ser_q_nxt;
            r_locked    <= w_locked_nxt;
        end
    end

    // Next-state and output logic.
    always_comb begin
        w_state_nxt     = r_state;
        w_k_nxt         = r_k;
        w_acc_i_nxt     = r_acc_i;
        w_acc_q_nxt     = r_acc_q;
        w_fin_i_nxt     = r_fin_i;
        w_fin_q_nxt     = r_fin_q;
        w_dec_pend_nxt  = 1'b0;
        w_sym_nxt       = r_sym;
        w_sym_valid_nxt = 1'b0;
        w_erase_nxt     = r_erase;
        w_dout_nxt      = r_dout;
        w_dvalid_nxt    = 1'b0;
        w_ser_q_nxt     = 1'b0;
        w_locked_nxt    = r_locked;

        // Slice one cycle after the last sample so the next symbol can start immediately.
        if (r_dec_pend) begin
            w_sym_nxt       = {r_fin_i[AW-1], r_fin_q[AW-1]};
            w_sym_valid_nxt = 1'b1;
            w_erase_nxt     = w_low;
        end

        if (r_sym_valid) begin
            w_dout_nxt   = r_sym[1];
            w_dvalid_nxt = 1'b1;
            w_ser_q_nxt  = 1'b1;
        end else if (r_ser_q) begin
            w_dout_nxt   = r_sym[0];
            w_dvalid_nxt = 1'b1;
        end

        case (r_state)
            HUNT: begin
                if (bus.SVin && bus.SYNCin) begin
                    w_acc_i_nxt  = w_s_ext;
                    w_acc_q_nxt  = w_s_ext;
                    w_k_nxt      = KW'(1);
                    w_state_nxt  = TRACK;
                    w_locked_nxt = 1'b1;
                end
            end
            TRACK: begin
                if (bus.SVin) begin
                    if (bus.SYNCin && (r_k != '0)) begin
                        // Realign: drop the partial symbol, this sample is phase 0.
                        w_acc_i_nxt = w_s_ext;
                        w_acc_q_nxt = w_s_ext;
                        w_k_nxt     = KW'(1);
                    end else if (r_k == KW'(SPS - 1)) begin
                        w_fin_i_nxt    = w_sum_i;
                        w_fin_q_nxt    = w_sum_q;
                        w_dec_pend_nxt = 1'b1;
                        w_acc_i_nxt    = '0;
                        w_acc_q_nxt    = '0;
                        w_k_nxt        = '0;
                    end else begin
                        w_acc_i_nxt = w_sum_i;
                        w_acc_q_nxt = w_sum_q;
                        w_k_nxt     = r_k + KW'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = HUNT;
            end
        endcase
    end

    assign bus.Symout   = r_sym;
    assign bus.SymValid = r_sym_valid;
    assign bus.Erase    = r_erase;
    assign bus.Dout     = r_dout;
    assign bus.DValid   = r_dvalid;
    assign bus.Locked   = r_locked;

endmodule

// File: tb/tb_qpsk_demod.sv
// Scoreboard bench for qpsk_demod: symbols driven from amplitude tables, decisions,
// erasure, latency and serial bits compared against a bench-side correlator model.
`timescale 1ns/1ps
module tb_qpsk_demod;

    localparam int SPS = 16;

    logic CLKin = 1'b0;
    logic RESET;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    qpsk_demod_if bus ();

    qpsk_demod #(.SPS(SPS), .THRESH(1024)) dut (
        .CLKin (CLKin),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLKin = ~CLKin;
    always @(posedge CLKin) cyc <= cyc + 1;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, time=%0t", $time);
        $fatal(1);
    end

    typedef struct {
        bit       er;
        bit [1:0] sym;
        int       last_cyc;
    } exp_t;

    typedef struct {
        bit       got;
        int       cyc;
        bit [1:0] sym;
        bit       er;
        bit       sv1;
        bit       v0, d0, v1, d1, v2, d2;
    } obs_t;

    exp_t exp_q[$];

    task automatic step();
        @(posedge CLKin);
        #1;
    endtask

    function automatic int cref(int k);
        return (k < SPS/4 || k >= 3*SPS/4) ? 1 : -1;
    endfunction

    function automatic int sref(int k);
        return (k < SPS/2) ? 1 : -1;
    endfunction

    // Drives n samples of amplitude (ai,aq); a full symbol pushes its model decision.
    task automatic drive_sym(input int ai, input int aq, input bit sync_first,
                             input bit gap, input int n);
        int   acc_i = 0;
        int   acc_q = 0;
        int   s;
        int   mag;
        exp_t e;
        for (int k = 0; k < n; k++) begin
            s          = ai * cref(k) + aq * sref(k);
            bus.Sin    = 12'(2048 + s);
            bus.SVin   = 1'b1;
            bus.SYNCin = sync_first && (k == 0);
            acc_i     += s * cref(k);
            acc_q     += s * sref(k);
            step();
            if (gap && k != n - 1) begin
                bus.SVin   = 1'b0;
                bus.SYNCin = 1'b1;
                bus.Sin    = 12'($urandom);
                step();
            end
        end
        bus.SVin   = 1'b0;
        bus.SYNCin = 1'b0;
        if (n == SPS) begin
            mag        = (acc_i < 0 ? -acc_i : acc_i) + (acc_q < 0 ? -acc_q : acc_q);
            e.sym      = {acc_i < 0, acc_q < 0};
            e.er       = (mag < 1024);
            e.last_cyc = cyc;
            exp_q.push_back(e);
        end
    endtask

    // Waits for a decision, then records the pulse width and the serializer cycles.
    task automatic collect(output obs_t o);
        o = '{default: 0};
        for (int i = 0; i < 40; i++) begin
            step();
            if (bus.SymValid === 1'b1) begin
                o.got = 1'b1;
                o.cyc = cyc;
                o.sym = bus.Symout;
                o.er  = bus.Erase;
                break;
            end
        end
        if (o.got) begin
            step(); o.sv1 = bus.SymValid; o.v0 = bus.DValid; o.d0 = bus.Dout;
            step(); o.v1 = bus.DValid; o.d1 = bus.Dout;
            step(); o.v2 = bus.DValid; o.d2 = bus.Dout;
        end
    endtask

    task automatic test_reset();
        bus.Sin = 12'd0; bus.SVin = 1'b0; bus.SYNCin = 1'b0;
        RESET = 1'b1;
        step(); step();
        n_checks++;
        if ({bus.Symout, bus.SymValid, bus.Erase, bus.Dout, bus.DValid, bus.Locked} !== 7'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got %b want 0000000",
                     {bus.Symout, bus.SymValid, bus.Erase, bus.Dout, bus.DValid, bus.Locked});
        end
        RESET = 1'b0;
    endtask

    task automatic test_hunt();
        bus.SVin = 1'b1; bus.SYNCin = 1'b0;
        for (int i = 0; i < 40; i++) begin
            bus.Sin = 12'($urandom);
            step();
            n_checks++;
            if ({bus.Symout, bus.SymValid, bus.Erase, bus.Dout, bus.DValid, bus.Locked} !== 7'b0) begin
                n_errors++;
                $display("FAIL hunt_idle cycle %0d: got %b want 0000000", i,
                         {bus.Symout, bus.SymValid, bus.Erase, bus.Dout, bus.DValid, bus.Locked});
            end
        end
        bus.SVin = 1'b0;
    endtask

    task automatic test_mapping();
        int   amp[4][2] = '{'{500, 500}, '{-500, -500}, '{-500, 500}, '{500, -500}};
        obs_t o;
        exp_t e;
        for (int t = 0; t < 4; t++) begin
            drive_sym(amp[t][0], amp[t][1], 1'b1, 1'b0, SPS);
            n_checks++;
            if (bus.Locked !== 1'b1) begin
                n_errors++;
                $display("FAIL mapping_locked %0d: got %b want 1", t, bus.Locked);
            end
            collect(o);
            e = exp_q.pop_front();
            n_checks++;
            if (!o.got) begin
                n_errors++;
                $display("FAIL mapping_symvalid %0d: no SymValid within 40 cycles", t);
            end else begin
                n_checks += 2;
                if ({o.sym, o.er, o.sv1, o.v0, o.d0, o.v1, o.d1, o.v2, o.d2} !==
                    {e.sym, e.er, 1'b0, 1'b1, e.sym[1], 1'b1, e.sym[0], 1'b0, e.sym[0]}) begin
                    n_errors++;
                    $display("FAIL mapping %0d: got sym=%b er=%b sv1=%b ser=%b%b%b%b%b%b want sym=%b er=%b",
                             t, o.sym, o.er, o.sv1, o.v0, o.d0, o.v1, o.d1, o.v2, o.d2, e.sym, e.er);
                end
                if (o.cyc - e.last_cyc !== 1) begin
                    n_errors++;
                    $display("FAIL mapping_latency %0d: got %0d want 1", t, o.cyc - e.last_cyc);
                end
            end
        end
    endtask

    task automatic test_erasure();
        int   amp[4][2] = '{'{0, 0}, '{32, 32}, '{31, 31}, '{-32, -32}};
        obs_t o;
        exp_t e;
        for (int t = 0; t < 4; t++) begin
            drive_sym(amp[t][0], amp[t][1], 1'b1, 1'b0, SPS);
            collect(o);
            e = exp_q.pop_front();
            n_checks++;
            if (!o.got) begin
                n_errors++;
                $display("FAIL erasure_symvalid %0d: no SymValid within 40 cycles", t);
            end else begin
                n_checks += 2;
                if ({o.sym, o.er, o.sv1, o.v0, o.d0, o.v1, o.d1, o.v2, o.d2} !==
                    {e.sym, e.er, 1'b0, 1'b1, e.sym[1], 1'b1, e.sym[0], 1'b0, e.sym[0]}) begin
                    n_errors++;
                    $display("FAIL erasure %0d: got sym=%b er=%b ser=%b%b%b%b%b%b want sym=%b er=%b",
                             t, o.sym, o.er, o.v0, o.d0, o.v1, o.d1, o.v2, o.d2, e.sym, e.er);
                end
                if (o.cyc - e.last_cyc !== 1) begin
                    n_errors++;
                    $display("FAIL erasure_latency %0d: got %0d want 1", t, o.cyc - e.last_cyc);
                end
            end
        end
    endtask

    task automatic test_gapped();
        obs_t o;
        exp_t e;
        drive_sym(500, 500, 1'b1, 1'b1, SPS);
        collect(o);
        e = exp_q.pop_front();
        n_checks++;
        if (!o.got) begin
            n_errors++;
            $display("FAIL gapped_symvalid: no SymValid within 40 cycles");
        end else begin
            n_checks += 2;
            if ({o.sym, o.er, o.sv1, o.v0, o.d0, o.v1, o.d1, o.v2, o.d2} !==
                {e.sym, e.er, 1'b0, 1'b1, e.sym[1], 1'b1, e.sym[0], 1'b0, e.sym[0]}) begin
                n_errors++;
                $display("FAIL gapped: got sym=%b er=%b ser=%b%b%b%b%b%b want sym=%b er=%b",
                         o.sym, o.er, o.v0, o.d0, o.v1, o.d1, o.v2, o.d2, e.sym, e.er);
            end
            if (o.cyc - e.last_cyc !== 1) begin
                n_errors++;
                $display("FAIL gapped_latency: got %0d want 1", o.cyc - e.last_cyc);
            end
        end
    endtask

    task automatic test_back_to_back();
        obs_t o[2];
        exp_t e;
        fork
            begin
                drive_sym(500, -500, 1'b1, 1'b0, SPS);
                drive_sym(-500, 500, 1'b0, 1'b0, SPS);
            end
            begin
                collect(o[0]);
                collect(o[1]);
            end
        join
        for (int t = 0; t < 2; t++) begin
            e = exp_q.pop_front();
            n_checks++;
            if (!o[t].got) begin
                n_errors++;
                $display("FAIL b2b_symvalid %0d: no SymValid within 40 cycles", t);
            end else begin
                n_checks += 2;
                if ({o[t].sym, o[t].er, o[t].sv1, o[t].v0, o[t].d0, o[t].v1, o[t].d1, o[t].v2, o[t].d2} !==
                    {e.sym, e.er, 1'b0, 1'b1, e.sym[1], 1'b1, e.sym[0], 1'b0, e.sym[0]}) begin
                    n_errors++;
                    $display("FAIL b2b %0d: got sym=%b er=%b want sym=%b er=%b",
                             t, o[t].sym, o[t].er, e.sym, e.er);
                end
                if (o[t].cyc - e.last_cyc !== 1) begin
                    n_errors++;
                    $display("FAIL b2b_latency %0d: got %0d want 1", t, o[t].cyc - e.last_cyc);
                end
            end
        end
    endtask

    task automatic test_realign();
        obs_t o;
        exp_t e;
        int   extra = 0;
        drive_sym(-500, -500, 1'b1, 1'b0, 7);
        drive_sym(500, 500, 1'b1, 1'b0, SPS);
        collect(o);
        e = exp_q.pop_front();
        n_checks++;
        if (!o.got) begin
            n_errors++;
            $display("FAIL realign_symvalid: no SymValid within 40 cycles");
        end else begin
            n_checks += 2;
            if ({o.sym, o.er, o.v0, o.d0, o.v1, o.d1} !== {e.sym, e.er, 1'b1, e.sym[1], 1'b1, e.sym[0]}) begin
                n_errors++;
                $display("FAIL realign: got sym=%b er=%b want sym=%b er=%b", o.sym, o.er, e.sym, e.er);
            end
            if (o.cyc - e.last_cyc !== 1) begin
                n_errors++;
                $display("FAIL realign_latency: got %0d want 1", o.cyc - e.last_cyc);
            end
        end
        for (int i = 0; i < 20; i++) begin
            step();
            if (bus.SymValid === 1'b1) extra++;
        end
        n_checks++;
        if (extra !== 0) begin
            n_errors++;
            $display("FAIL realign_extra: got %0d SymValid pulses want 0", extra);
        end
    endtask

    task automatic test_reset_mid_serial();
        exp_t e;
        bit   got = 1'b0;
        int   seen = 0;
        drive_sym(-500, -500, 1'b1, 1'b0, SPS);
        e = exp_q.pop_front();
        for (int i = 0; i < 40 && !got; i++) begin
            step();
            got = (bus.SymValid === 1'b1);
        end
        n_checks++;
        if (!got || bus.Symout !== e.sym) begin
            n_errors++;
            $display("FAIL rst_serial_sym: got valid=%b sym=%b want valid=1 sym=%b", got, bus.Symout, e.sym);
        end
        step();
        n_checks++;
        if ({bus.DValid, bus.Dout} !== {1'b1, e.sym[1]}) begin
            n_errors++;
            $display("FAIL rst_serial_bi: got %b want %b", {bus.DValid, bus.Dout}, {1'b1, e.sym[1]});
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        n_checks++;
        if ({bus.DValid, bus.Dout, bus.Locked, bus.SymValid, bus.Symout} !== 6'b0) begin
            n_errors++;
            $display("FAIL rst_serial_clear: got %b want 000000",
                     {bus.DValid, bus.Dout, bus.Locked, bus.SymValid, bus.Symout});
        end
        bus.SVin = 1'b1; bus.SYNCin = 1'b0;
        for (int i = 0; i < 24; i++) begin
            bus.Sin = 12'($urandom);
            step();
            if (bus.SymValid === 1'b1 || bus.DValid === 1'b1 || bus.Locked === 1'b1) seen++;
        end
        bus.SVin = 1'b0;
        n_checks++;
        if (seen !== 0) begin
            n_errors++;
            $display("FAIL rst_serial_hunt: got %0d active cycles want 0", seen);
        end
    endtask

    initial begin
        test_reset();
        test_hunt();
        test_mapping();
        test_erasure();
        test_gapped();
        test_back_to_back();
        test_realign();
        test_reset_mid_serial();
        n_checks++;
        if (exp_q.size() !== 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/qpsk_demod.md
Name: qpsk_demod

Overview:
Receive-side counterpart of the QPSK transmit chain. Takes the 12-bit offset-binary sample stream from the ADC front end at carrier rate. Correlates each symbol period against sign-only cosine and sine references, slices the I/Q accumulators into a 2-bit symbol, and re-serializes the symbol bits, mirroring the transmitter's serial data input. Sits between the ADC capture logic and the downstream bit sink / BER checker.

Parameters:
SPS, 16, samples per symbol (one carrier cycle per symbol); power of two, >= 4.
THRESH, 1024, minimum |accI|+|accQ| for a valid decision; below it the symbol is flagged as an erasure.

Ports:
CLKin  input  1  system clock; all logic rising-edge.
RESET  input  1  synchronous, active-high reset.
Sin  input  12  ADC sample, offset binary, midscale 2048.
SVin  input  1  sample valid; Sin is consumed only on cycles with SVin=1.
SYNCin  input  1  symbol-boundary marker, sampled only when SVin=1.
Symout  output  2  last decided symbol {bI,bQ}.
SymValid  output  1  one-cycle pulse when Symout updates.
Erase  output  1  qualifies Symout: 1 means energy was below THRESH.
Dout  output  1  serial symbol bits, bI first, then bQ.
DValid  output  1  high on each cycle that Dout carries a bit.
Locked  output  1  high once the first SYNCin has been accepted.

Behaviour:
- Reset (RESET=1 at a clock edge): Symout=0, SymValid=0, Erase=0, Dout=0, DValid=0, Locked=0. Phase counter=0, accumulators=0, state=HUNT. Takes priority over all other inputs, including mid-symbol and mid-serialization; partial symbols are discarded.
- Sample conversion: s = Sin - 2048, 13-bit signed.
- Phase index k = 0..SPS-1.
  - cref(k) = +1 for k < SPS/4 or k >= 3*SPS/4, else -1.
  - sref(k) = +1 for k < SPS/2, else -1.
- Accumulators accI and accQ are signed, width 13+log2(SPS) (17 at default). They cannot overflow.
- States:
  - HUNT: samples ignored, no outputs. On SVin=1 and SYNCin=1, the sample is taken as k=0: accI=s*cref(0), accQ=s*sref(0), k=1. Go to TRACK and set Locked=1 on the same edge.
  - TRACK: on each SVin=1, accI += s*cref(k), accQ += s*sref(k), and k increments.
    - When the sample at k=SPS-1 is accumulated, on the next edge: Symout={accI_final<0, accQ_final<0}, SymValid=1 for one cycle, Erase=(|accI|+|accQ| < THRESH) computed in 18-bit unsigned. Accumulators clear and k wraps to 0.
    - SVin=0: hold all state, no accumulation.
    - SYNCin=1 with SVin=1 at k!=0: realign. The current partial symbol is discarded with no SymValid, this sample is taken as k=0, and Locked stays 1.
    - SYNCin=1 at k=0: no effect beyond normal accumulation.
- Latency: SymValid rises 1 cycle after the edge that accepts the k=SPS-1 sample.
- Serializer:
  - Cycle after SymValid: Dout=bI, DValid=1.
  - Next cycle: Dout=bQ, DValid=1.
  - Then DValid=0 and Dout holds its last value.
  - Erased symbols are still serialized.
  - A new symbol needs at least SPS >= 4 cycles, so serializer overlap is impossible.
- Mapping (Gray): phase 45 deg -> 00, 135 deg -> 10, 225 deg -> 11, 315 deg -> 01. A zero accumulator slices as 0.

Test Plan:
- Reset then SVin=1 continuously with no SYNCin for 40 cycles -> Locked=0, SymValid never asserts, all outputs 0.
- SYNCin on the first sample; 16 samples Sin=2048+500*cref(k)+500*sref(k) -> accI=accQ=8000, Symout=00, Erase=0, SymValid 1 cycle after the 16th sample, then Dout 0,0 with DValid for 2 cycles.
- Same stimulus with the ±500 terms negated -> Symout=11, Dout 1,1. I-only negated -> 10. Q-only negated -> 01.
- Sin=2048 constant for one symbol -> Symout=00, Erase=1, still serialized. Amplitude 32 per axis (sum 1024) -> Erase=0; amplitude 31 (992) -> Erase=1.
- SVin toggling 1,0,1,0 through a 00 symbol -> same result as the continuous case; SymValid delayed to 1 cycle after the 16th valid sample.
- SYNCin at k=7 mid-symbol -> no SymValid for the partial symbol; the next decision occurs 16 valid samples after the realign. RESET asserted during Dout=bI -> DValid=0 next cycle and state=HUNT.
